// File: rtl/scl_gen_pkg.sv
// Shared types and default phase timing for the timed SCL generator.
package scl_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_STALL,
      ST_HIGH
   } scl_state_e;

   localparam int PP_LOW_DEF  = 2;
   localparam int PP_HIGH_DEF = 2;
   localparam int OD_LOW_DEF  = 10;
   localparam int OD_HIGH_DEF = 2;

   function automatic int phase_len(input logic pp_od, input logic is_low);
      if (pp_od)
         return is_low ? PP_LOW_DEF : PP_HIGH_DEF;
      else
         return is_low ? OD_LOW_DEF : OD_HIGH_DEF;
   endfunction

endpackage

// File: rtl/scl_phase_counter.sv
// Loadable down-counter shared by the LOW, STALL and HIGH phases.
module scl_phase_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && count != '0)
         count <= count - CNT_W'(1);
   end

   // The counter holds "cycles remaining minus one", so zero marks the final cycle.
   assign last = (count == '0);

endmodule

// File: rtl/scl_gen_timed.sv
// I3C SDR SCL generator with programmable low/high phases, stall engine and idle park.
module scl_gen_timed
   import scl_gen_pkg::*;
#(
   parameter int PP_LOW  = phase_len(1'b1, 1'b1),
   parameter int PP_HIGH = phase_len(1'b1, 1'b0),
   parameter int OD_LOW  = phase_len(1'b0, 1'b1),
   parameter int OD_HIGH = phase_len(1'b0, 1'b0),
   parameter int CNT_W   = 5,
   parameter int STALL_W = 5
) (
   input  logic               i_sdr_ctrl_clk,
   input  logic               i_sdr_ctrl_rst_n,
   input  logic               i_sdr_scl_gen_pp_od,
   input  logic               i_sdr_ctrl_scl_idle,
   input  logic               i_scl_gen_stall,
   input  logic [STALL_W-1:0] i_stall_cycles,
   output logic               o_scl,
   output logic               o_scl_pos_edge,
   output logic               o_scl_neg_edge,
   output logic               o_stall_done,
   output logic               o_scl_stall
);

   scl_state_e       state, next_state;
   logic             load, en, last, next_last, next_scl, stall_req;
   logic [CNT_W-1:0] load_val, count, next_count;
   logic [CNT_W-1:0] low_len, high_len, stall_len;

   assign low_len   = i_sdr_scl_gen_pp_od ? CNT_W'(PP_LOW - 1)  : CNT_W'(OD_LOW - 1);
   assign high_len  = i_sdr_scl_gen_pp_od ? CNT_W'(PP_HIGH - 1) : CNT_W'(OD_HIGH - 1);
   assign stall_len = CNT_W'(i_stall_cycles - STALL_W'(1));
   assign stall_req = i_scl_gen_stall && (i_stall_cycles != '0);

   scl_phase_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (i_sdr_ctrl_clk),
      .rst_n    (i_sdr_ctrl_rst_n),
      .load     (load),
      .en       (en),
      .load_val (load_val),
      .count    (count),
      .last     (last)
   );

   always_comb begin
      next_state = state;
      load       = 1'b0;
      en         = 1'b0;
      load_val   = low_len;
      case (state)
         ST_IDLE: begin
            if (!i_sdr_ctrl_scl_idle) begin
               next_state = ST_LOW;
               load       = 1'b1;
            end
         end
         ST_LOW: begin
            en = 1'b1;
            if (last) begin
               if (stall_req) begin
                  next_state = ST_STALL;
                  load       = 1'b1;
                  load_val   = stall_len;
               end else if (i_sdr_ctrl_scl_idle) begin
                  next_state = ST_IDLE;
               end else begin
                  next_state = ST_HIGH;
                  load       = 1'b1;
                  load_val   = high_len;
               end
            end
         end
         ST_STALL: begin
            en = 1'b1;
            if (last) begin
               if (i_sdr_ctrl_scl_idle) begin
                  next_state = ST_IDLE;
               end else begin
                  next_state = ST_HIGH;
                  load       = 1'b1;
                  load_val   = high_len;
               end
            end
         end
         ST_HIGH: begin
            en = 1'b1;
            if (last) begin
               if (i_sdr_ctrl_scl_idle) begin
                  next_state = ST_IDLE;
               end else begin
                  next_state = ST_LOW;
                  load       = 1'b1;
               end
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Look ahead at the counter so done can be registered yet land on the final cycle.
   assign next_count = load ? load_val : ((en && !last) ? count - CNT_W'(1) : count);
   assign next_last  = (next_count == '0);
   assign next_scl   = (next_state == ST_IDLE) || (next_state == ST_HIGH);

   always_ff @(posedge i_sdr_ctrl_clk) begin
      if (!i_sdr_ctrl_rst_n) begin
         state          <= ST_IDLE;
         o_scl          <= 1'b1;
         o_scl_pos_edge <= 1'b0;
         o_scl_neg_edge <= 1'b0;
         o_stall_done   <= 1'b0;
         o_scl_stall    <= 1'b0;
      end else begin
         state          <= next_state;
         o_scl          <= next_scl;
         o_scl_pos_edge <= !o_scl && next_scl;
         o_scl_neg_edge <= o_scl && !next_scl;
         o_scl_stall    <= (next_state == ST_STALL);
         o_stall_done   <= next_last &&
                           ((next_state == ST_STALL) ||
                            (next_state == ST_LOW && i_scl_gen_stall && i_stall_cycles == '0));
      end
   end

endmodule

// File: tb/tb_scl_gen_timed.sv
// Self-checking bench: phase-length scoreboard plus table-driven SCL periods and corner sequences.
module tb_scl_gen_timed;
   import scl_gen_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pp_od = 1'b1;
   logic       idle = 1'b0;
   logic       stall = 1'b0;
   logic [4:0] cycles = 5'd0;
   logic       scl, pos_edge, neg_edge, stall_done, scl_stall;

   always #5 clk = ~clk;

   scl_gen_timed dut (
      .i_sdr_ctrl_clk      (clk),
      .i_sdr_ctrl_rst_n    (rst_n),
      .i_sdr_scl_gen_pp_od (pp_od),
      .i_sdr_ctrl_scl_idle (idle),
      .i_scl_gen_stall     (stall),
      .i_stall_cycles      (cycles),
      .o_scl               (scl),
      .o_scl_pos_edge      (pos_edge),
      .o_scl_neg_edge      (neg_edge),
      .o_stall_done        (stall_done),
      .o_scl_stall         (scl_stall)
   );

   typedef struct {
      logic       pp_od;
      logic       stall;
      logic [4:0] cycles;
      int         exp_low;
      int         exp_stall;
   } vec_t;

   vec_t       vecs[9];
   logic [7:0] exp_q[$];
   logic [7:0] stall_q[$];
   int         errors = 0;
   int         checks = 0;
   int         done_total = 0;
   int         exp_done = 0;
   logic       mon_en = 1'b0;
   logic       prev_scl, prev_stall;
   logic [7:0] mon_e;
   int         run, srun;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sel: 0 pos_edge, 1 neg_edge, 2 stall_done, 3 scl_stall
   task automatic wait_for(input int sel, input string name);
      logic seen;
      int   n;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 200) begin
         tick();
         n++;
         case (sel)
            0: seen = pos_edge;
            1: seen = neg_edge;
            2: seen = stall_done;
            default: seen = scl_stall;
         endcase
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: got no pulse within 200 cycles, required one", name);
      end
   endtask

   function automatic logic [7:0] ph(input logic lvl, input int len);
      return {lvl, 7'(len)};
   endfunction

   // Scoreboard side: measure each completed SCL level and stall window.
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_scl   = scl;
         prev_stall = scl_stall;
         run        = 1;
         srun       = 0;
      end else begin
         check_eq("pos_edge_align", pos_edge, scl & ~prev_scl);
         check_eq("neg_edge_align", neg_edge, ~scl & prev_scl);
         if (scl !== prev_scl) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_edge: got scl=%0b after %0d cycles, required no transition", scl, run);
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("phase_level", prev_scl, mon_e[7]);
               if (mon_e[6:0] != 7'd0) check_eq("phase_len", run, mon_e[6:0]);
            end
            run = 1;
         end else begin
            run++;
         end
         if (scl_stall === 1'b1) begin
            srun++;
            check_eq("scl_low_in_stall", scl, 0);
         end else if (prev_stall === 1'b1) begin
            if (stall_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_stall: got stall of %0d cycles, required none", srun);
            end else begin
               check_eq("stall_len", srun, stall_q.pop_front());
            end
            srun = 0;
         end
         if (stall_done === 1'b1) done_total++;
         prev_scl   = scl;
         prev_stall = scl_stall;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, required end within 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b1, 1'b0, 5'd0,  2,  0};
      vecs[1] = '{1'b1, 1'b0, 5'd0,  2,  0};
      vecs[2] = '{1'b0, 1'b0, 5'd0,  10, 0};
      vecs[3] = '{1'b0, 1'b0, 5'd0,  10, 0};
      vecs[4] = '{1'b1, 1'b1, 5'd18, 20, 18};
      vecs[5] = '{1'b1, 1'b0, 5'd0,  2,  0};
      vecs[6] = '{1'b1, 1'b1, 5'd0,  2,  0};
      vecs[7] = '{1'b0, 1'b1, 5'd3,  13, 3};
      vecs[8] = '{1'b1, 1'b1, 5'd1,  3,  1};

      // Reset for 3 clocks with the controller already requesting activity.
      tick();
      prev_scl   = 1'b1;
      prev_stall = 1'b0;
      run        = 1;
      srun       = 0;
      mon_en     = 1'b1;
      repeat (2) tick();
      check_eq("reset_scl", scl, 1);
      check_eq("reset_pos", pos_edge, 0);
      check_eq("reset_neg", neg_edge, 0);
      check_eq("reset_done", stall_done, 0);
      check_eq("reset_stall", scl_stall, 0);

      exp_q.push_back(ph(1'b1, 0));
      exp_q.push_back(ph(1'b0, 2));
      rst_n = 1'b1;
      tick();
      check_eq("first_low_scl", scl, 0);
      check_eq("first_neg_edge", neg_edge, 1);

      // One SCL period per row; inputs change during HIGH so they govern the next LOW.
      for (int i = 0; i < 9; i++) begin
         wait_for(0, "pos_edge");
         pp_od  = vecs[i].pp_od;
         stall  = vecs[i].stall;
         cycles = vecs[i].cycles;
         exp_q.push_back(ph(1'b1, 2));
         exp_q.push_back(ph(1'b0, vecs[i].exp_low));
         if (vecs[i].stall) begin
            exp_done++;
            if (vecs[i].cycles != 5'd0) stall_q.push_back(8'(vecs[i].exp_stall));
            wait_for(2, "stall_done");
            stall = 1'b0;
         end
      end

      // Stall left asserted over two periods gives two back-to-back stalls.
      wait_for(0, "pos_edge");
      pp_od  = 1'b1;
      stall  = 1'b1;
      cycles = 5'd3;
      exp_q.push_back(ph(1'b1, 2));
      exp_q.push_back(ph(1'b0, 5));
      stall_q.push_back(8'd3);
      exp_done++;
      wait_for(2, "stall_done_first");
      wait_for(0, "pos_edge");
      exp_q.push_back(ph(1'b1, 2));
      exp_q.push_back(ph(1'b0, 5));
      stall_q.push_back(8'd3);
      exp_done++;
      wait_for(2, "stall_done_second");
      stall = 1'b0;

      // Idle requested mid-LOW: SCL rises at LOW end and parks high.
      wait_for(0, "pos_edge");
      exp_q.push_back(ph(1'b1, 2));
      exp_q.push_back(ph(1'b0, 2));
      wait_for(1, "neg_edge");
      idle = 1'b1;
      repeat (8) tick();
      check_eq("parked_high", scl, 1);
      check_eq("queue_drained", exp_q.size(), 0);
      exp_q.push_back(ph(1'b1, 0));
      exp_q.push_back(ph(1'b0, 2));
      idle = 1'b0;
      tick();
      check_eq("low_after_idle_drop", scl, 0);
      check_eq("neg_after_idle_drop", neg_edge, 1);

      // Reset in the middle of a stall.
      wait_for(0, "pos_edge");
      exp_q.push_back(ph(1'b1, 2));
      stall  = 1'b1;
      cycles = 5'd10;
      wait_for(3, "scl_stall");
      repeat (3) tick();
      check_eq("stall_active", scl_stall, 1);
      check_eq("queue_before_reset", exp_q.size(), 0);
      check_eq("stall_queue_before_reset", stall_q.size(), 0);
      mon_en = 1'b0;
      rst_n  = 1'b0;
      tick();
      check_eq("reset_in_stall_scl", scl, 1);
      check_eq("reset_in_stall_stall", scl_stall, 0);
      check_eq("reset_in_stall_done", stall_done, 0);
      check_eq("reset_in_stall_pos", pos_edge, 0);
      stall = 1'b0;
      idle  = 1'b1;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check_eq("idle_after_reset", scl, 1);
      check_eq("done_pulse_total", done_total, exp_done);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scl_gen_timed.md
# scl_gen_timed

Parametrised I3C SDR SCL generator with an integrated stall engine, replacing the fixed-ratio SCL generator plus separate staller pair in the SDR controller. It produces SCL with independently programmable low/high phase lengths for push-pull and open-drain modes. It can freeze SCL low for a variable number of system clocks on request, and parks SCL high when the controller is idle. It sits between the SDR controller FSM and the SCL pad driver.

## Interface
- `PP_LOW`, 2: push-pull low-phase length, system clocks (≥1)
- `PP_HIGH`, 2: push-pull high-phase length (≥1)
- `OD_LOW`, 10: open-drain low-phase length (≥1)
- `OD_HIGH`, 2: open-drain high-phase length (≥1)
- `CNT_W`, 5: phase counter width; must hold max(phase lengths, 2^STALL_W−1)
- `STALL_W`, 5: stall-cycle count width
- `i_sdr_ctrl_clk`  in  1  system clock
- `i_sdr_ctrl_rst_n`  in  1  reset, synchronous, active-low
- `i_sdr_scl_gen_pp_od`  in  1  1 = push-pull timing, 0 = open-drain timing
- `i_sdr_ctrl_scl_idle`  in  1  request SCL park high
- `i_scl_gen_stall`  in  1  level stall request
- `i_stall_cycles`  in  STALL_W  stall length, system clocks
- `o_scl`  out  1  SCL level (registered)
- `o_scl_pos_edge`  out  1  one-cycle pulse, first cycle `o_scl`=1 after 0
- `o_scl_neg_edge`  out  1  one-cycle pulse, first cycle `o_scl`=0 after 1
- `o_stall_done`  out  1  one-cycle pulse, last cycle of a stall
- `o_scl_stall`  out  1  high while SCL is being held by a stall

## Operation
- States: IDLE, LOW, STALL, HIGH.
- Reset values: state IDLE, `o_scl`=1, all pulses 0, `o_scl_stall`=0, counter 0.
- **IDLE:** `o_scl`=1. If `i_sdr_ctrl_scl_idle`=0, go to LOW next cycle (neg_edge pulse).
- **LOW:**
  - Lasts L cycles, where L = PP_LOW or OD_LOW.
  - The mode is sampled on the cycle LOW is entered, so a mode change takes effect at the next phase boundary only.
- **End of LOW** (last cycle), checked in priority order:
  1. `i_scl_gen_stall`=1 and `i_stall_cycles`≠0: go to STALL, load the count.
  2. `i_scl_gen_stall`=1 and `i_stall_cycles`=0: no extension; `o_stall_done` pulses on this last LOW cycle.
  3. `i_sdr_ctrl_scl_idle`=1: go to IDLE (pos_edge pulse).
  4. Otherwise: go to HIGH.
- **STALL:**
  - `o_scl`=0, `o_scl_stall`=1, for exactly N=`i_stall_cycles` cycles (value sampled at entry).
  - `o_stall_done`=1 on the Nth cycle.
  - Exit to IDLE if idle is requested, else to HIGH.
- **HIGH:** lasts H cycles (PP_HIGH or OD_HIGH), then goes to LOW. If idle is requested at the end of HIGH, go to IDLE instead and SCL stays 1 with no edge.
- Stall is level-sensitive: if `i_scl_gen_stall` is still 1 at the next LOW end, a new stall starts. The controller must drop it after `o_stall_done`.
- Changes to `i_scl_gen_stall` during HIGH or mid-LOW have no effect until the end of LOW.
- Reset mid-operation: next cycle returns to IDLE values and drops any pending stall.

## Timing
- All outputs are registered; zero combinational input→output paths.
- SCL period = L+H clocks without stall, L+N+H with stall.
- Edge pulses coincide with the `o_scl` transition cycle.
- In steady push-pull with defaults: 50 % duty, period 4 clocks. Open-drain: period 12.
- `o_scl_neg_edge` appears 1 cycle after the idle deassertion is sampled.

## Structure
- Package `scl_gen_pkg`:
  - `scl_state_e` enum typedef
  - default phase constants
  - helper function `phase_len(pp_od, is_low)`
- Sub-module `scl_phase_counter`: loadable down-counter (CNT_W), with load/enable inputs and a `last` flag output. It is instantiated once and shared by the LOW, HIGH and STALL states.

## Test plan
- Reset 3 clocks, idle=0, pp_od=1 → `o_scl` toggles 2 low / 2 high. A neg_edge pulse arrives 1 clock after reset release; pos/neg pulses align with transitions.
- pp_od switched 1→0 mid-HIGH → current HIGH completes at 2 clocks; the next LOW is 10 clocks, HIGH 2.
- Stall with stall_cycles=18, deasserted on `o_stall_done` → SCL low for 2+18 clocks, `o_scl_stall` high 18 clocks, single done pulse, then normal toggling.
- Stall with stall_cycles=0 → no period extension; `o_stall_done` pulses on the last LOW cycle.
- Stall held high across two periods → two consecutive stalls, two done pulses.
- Idle asserted mid-LOW → SCL rises at LOW end and stays high. Idle dropped → LOW starts next clock. Reset asserted during STALL → `o_scl`=1 next clock, no done pulse.
